output_layer_sequencer: RTL and testbench
=========================================

# output_layer_sequencer

Sequences the output layer of the inference datapath. On a start pulse it walks the shared index `sel` from 0 to N_IN-1 over the hidden-activation buffer and the 10-port output weight memory, accumulating 10 signed dot products in parallel. It then runs a serial argmax over the 10 accumulators and reports the winning class with a one-cycle `done` pulse. It sits between the hidden-layer controller, which issues `start`, and the result/display logic.

## Interface
- `N_IN`, 20, number of hidden activations (weight row stride); legal range 1..255
- `ACC_W`, 24, accumulator width in bits; must be ≥ 16 + ceil(log2(N_IN))
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  request one output-layer pass; sampled only in IDLE
- `sel`  out  32  index driven to both the weight memory (`input_sel`) and the hidden buffer read address
- `hidden_data`  in  8  unsigned activation at `sel`, combinational read
- `w0`..`w9`  in  8 each  signed two's-complement weights for outputs 0..9 at `sel`, combinational read
- `busy`  out  1  high in MAC, ARG and DONE
- `done`  out  1  one-cycle pulse, result valid
- `class_out`  out  4  winning output index 0..9
- `max_score`  out  ACC_W  signed accumulator value of the winner

## Operation
- States: IDLE → MAC → ARG → DONE → IDLE; binary encoded.
- IDLE: `start`=1 at an edge → clear `acc0`..`acc9`, set `idx`=0, go to MAC.
- MAC: `sel`=`idx`. Each edge performs `acc_k += $signed({1'b0,hidden_data}) * $signed(w_k)` for k=0..9, giving a 17-bit signed product sign-extended to ACC_W. `idx` increments each edge. The edge with `idx`=N_IN-1 performs the last accumulate, sets `aidx`=0 and moves to ARG.
- ARG: one accumulator per cycle, index `aidx`=0..9.
  - `aidx`=0 loads `best`=`acc0` and `best_idx`=0.
  - Every later index replaces `best` only on a strict signed greater-than, so ties go to the lowest index.
  - The edge with `aidx`=9 writes `class_out`/`max_score` and goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `sel`=0 outside MAC. Only the low bits carry `idx`; the upper bits are zero.
- `start` is ignored in MAC, ARG and DONE. It is not queued.
- `class_out`/`max_score` hold their value from DONE until the next DONE. They are not cleared when a new pass starts.
- No overflow saturation; the ACC_W rule guarantees no wrap.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `sel`=0, `busy`=0, `done`=0, `class_out`=0, `max_score`=0. Accumulators, `idx`, `aidx`, `best` and `best_idx` are all 0.
- Reset mid-pass aborts immediately. No `done` is produced. After release the block waits in IDLE for a new `start`.
- Let E0 be the edge that accepts `start`.
  - MAC accumulates on edges E1..E(N_IN).
  - ARG runs on edges E(N_IN+1)..E(N_IN+10).
  - `done` is high between E(N_IN+10) and E(N_IN+11): with default N_IN=20, `done` is high in the cycle after the 30th edge following E0.
  - `busy` rises after E0 and falls after E(N_IN+11).
- Back-to-back passes: the earliest next acceptance is E(N_IN+12). `start` held high continuously yields one pass every N_IN+12 edges.
- Memory reads are combinational. `hidden_data`/`w_k` must be stable in the same cycle `sel` is driven; there is no read latency.

## Test plan
- All weights 0x01, all activations 0x02 → every acc = 40 (tie); `class_out`=0, `max_score`=40. `done` 30 edges after E0, width 1 cycle.
- Row 7 weights 0x7F, other rows 0x00, activations 0xFF → `class_out`=7, `max_score`=647700 (20·127·255); no overflow at ACC_W=24.
- Rows 0–2 and 4–9 weights 0x80 (−128), row 3 weights 0xFF (−1), activations 0xFF → `class_out`=3, `max_score`=−5100. Checks signed multiply/compare and zero-extended activations.
- `sel` trace: during MAC it equals 0,1,…,19 on consecutive cycles and is 0 otherwise. `start` pulsed at MAC cycle 5 and in DONE is ignored: exactly one `done`, and no restart on the following edge.
- Assert `rst_n`=0 at MAC cycle 10 → outputs return to reset values asynchronously and no `done` occurs. After a new `start`, the full pass gives the correct result and stale partial sums do not leak in.
- `start` held high for 100 cycles with random weights/activations → a `done` every 32 edges; each result matches the reference model.

Source files
------------

// File: rtl/output_layer_sequencer.sv
// rtl/output_layer_sequencer.sv - output layer MAC over N_IN activations, then a serial argmax over 10 classes
module output_layer_sequencer #(
  parameter int N_IN  = 20,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [31:0]      sel,
  input  logic [7:0]       hidden_data,
  input  logic [7:0]       w0,
  input  logic [7:0]       w1,
  input  logic [7:0]       w2,
  input  logic [7:0]       w3,
  input  logic [7:0]       w4,
  input  logic [7:0]       w5,
  input  logic [7:0]       w6,
  input  logic [7:0]       w7,
  input  logic [7:0]       w8,
  input  logic [7:0]       w9,
  output logic             busy,
  output logic             done,
  output logic [3:0]       class_out,
  output logic [ACC_W-1:0] max_score
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ARG, S_DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_IN - 1);

  state_t                  state;
  state_t                  state_next;
  logic [7:0]              idx;
  logic [3:0]              aidx;
  logic signed [ACC_W-1:0] acc [10];
  logic signed [ACC_W-1:0] best;
  logic [3:0]              best_idx;
  logic [7:0]              w [10];
  logic signed [16:0]      prod [10];
  logic signed [ACC_W-1:0] cur_acc;
  logic                    cur_gt;

  assign w[0] = w0;
  assign w[1] = w1;
  assign w[2] = w2;
  assign w[3] = w3;
  assign w[4] = w4;
  assign w[5] = w5;
  assign w[6] = w6;
  assign w[7] = w7;
  assign w[8] = w8;
  assign w[9] = w9;

  // Activation is zero-extended, weight sign-extended; the 17-bit product cannot overflow.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      prod[k] = $signed({9'b0, hidden_data}) * $signed({{9{w[k][7]}}, w[k]});
    end
  end

  always_comb begin
    cur_acc = '0;
    for (int k = 0; k < 10; k++) begin
      if (aidx == 4'(k)) cur_acc = acc[k];
    end
    cur_gt = cur_acc > best;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_MAC;
      S_MAC:   if (idx == LAST_IDX) state_next = S_ARG;
      S_ARG:   if (aidx == 4'd9) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 10; k++) acc[k] <= '0;
      idx       <= '0;
      aidx      <= '0;
      best      <= '0;
      best_idx  <= '0;
      class_out <= '0;
      max_score <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 10; k++) acc[k] <= '0;
            idx  <= '0;
            aidx <= '0;
          end
        end
        S_MAC: begin
          for (int k = 0; k < 10; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
          idx <= idx + 8'd1;
          if (idx == LAST_IDX) aidx <= '0;
        end
        S_ARG: begin
          // Strict greater-than keeps the lowest index on ties.
          if (aidx == 4'd0 || cur_gt) begin
            best     <= cur_acc;
            best_idx <= aidx;
          end
          if (aidx == 4'd9) begin
            class_out <= cur_gt ? 4'd9 : best_idx;
            max_score <= cur_gt ? cur_acc : best;
          end
          aidx <= aidx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign sel  = (state == S_MAC) ? {24'b0, idx} : 32'b0;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// tb/tb_output_layer_sequencer.sv - randomized self-checking bench for output_layer_sequencer
module tb_output_layer_sequencer;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] sel;
  logic [7:0]  hidden_data;
  logic [7:0]  w0, w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic        busy;
  logic        done;
  logic [3:0]  class_out;
  logic [23:0] max_score;

  logic [7:0]  hid_mem [N];
  logic [7:0]  w_mem [10][N];

  int     checks = 0;
  int     errors = 0;
  int     prev_cls;
  longint prev_score;

  always #5 clk = ~clk;

  output_layer_sequencer #(.N_IN(N), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .hidden_data(hidden_data),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
    .busy(busy), .done(done), .class_out(class_out), .max_score(max_score)
  );

  // Combinational memories addressed by sel; out-of-range reads return zero.
  logic in_rng;
  assign in_rng      = (sel < 32'(N));
  assign hidden_data = in_rng ? hid_mem[sel[4:0]] : 8'h00;
  assign w0 = in_rng ? w_mem[0][sel[4:0]] : 8'h00;
  assign w1 = in_rng ? w_mem[1][sel[4:0]] : 8'h00;
  assign w2 = in_rng ? w_mem[2][sel[4:0]] : 8'h00;
  assign w3 = in_rng ? w_mem[3][sel[4:0]] : 8'h00;
  assign w4 = in_rng ? w_mem[4][sel[4:0]] : 8'h00;
  assign w5 = in_rng ? w_mem[5][sel[4:0]] : 8'h00;
  assign w6 = in_rng ? w_mem[6][sel[4:0]] : 8'h00;
  assign w7 = in_rng ? w_mem[7][sel[4:0]] : 8'h00;
  assign w8 = in_rng ? w_mem[8][sel[4:0]] : 8'h00;
  assign w9 = in_rng ? w_mem[9][sel[4:0]] : 8'h00;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(output int cls, output longint score);
    longint s;
    cls   = 0;
    score = 0;
    for (int k = 0; k < 10; k++) begin
      s = 0;
      for (int i = 0; i < N; i++)
        s += longint'(hid_mem[i]) * longint'($signed(w_mem[k][i]));
      if (k == 0 || s > score) begin
        score = s;
        cls   = k;
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      hid_mem[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 10; k++) w_mem[k][i] = 8'($urandom);
    end
  endtask

  task automatic fill_const(input logic [7:0] act, input logic [7:0] wdef,
                            input int row, input logic [7:0] wrow);
    for (int i = 0; i < N; i++) begin
      hid_mem[i] = act;
      for (int k = 0; k < 10; k++) w_mem[k][i] = (k == row) ? wrow : wdef;
    end
  endtask

  // One pass; j counts edges after E0, sampled on the falling edge.
  // stray=1 pulses start mid-MAC and during DONE, both of which must be ignored.
  task automatic run_pass(input string tag, input bit stray, input int exp_cls, input longint exp_score);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 33; j++) begin
      @(negedge clk);
      check({tag, "_sel"}, longint'(sel), (j < N) ? longint'(j) : 0);
      check({tag, "_done"}, longint'(done), (j == N + 10) ? 1 : 0);
      check({tag, "_busy"}, longint'(busy), (j <= N + 10) ? 1 : 0);
      if (j == 5) begin
        check({tag, "_hold_cls"}, longint'(class_out), longint'(prev_cls));
        check({tag, "_hold_score"}, longint'($signed(max_score)), prev_score);
      end
      start = stray && (j == 5 || j == N + 10);
    end
    start = 1'b0;
    check({tag, "_cls"}, longint'(class_out), longint'(exp_cls));
    check({tag, "_score"}, longint'($signed(max_score)), exp_score);
    prev_cls   = exp_cls;
    prev_score = exp_score;
  endtask

  initial begin
    int     mcls;
    longint mscore;
    int     done_cnt;

    rst_n = 1'b0;
    start = 1'b0;
    fill_const(8'h00, 8'h00, 0, 8'h00);
    prev_cls   = 0;
    prev_score = 0;
    repeat (3) @(negedge clk);
    check("rst_sel", longint'(sel), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_cls", longint'(class_out), 0);
    check("rst_score", longint'($signed(max_score)), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_const(8'h02, 8'h01, 0, 8'h01);
    run_pass("tie", 1'b0, 0, 40);

    fill_const(8'hFF, 8'h00, 7, 8'h7F);
    run_pass("row7", 1'b1, 7, 647700);

    fill_const(8'hFF, 8'h80, 3, 8'hFF);
    run_pass("neg", 1'b0, 3, -5100);

    fill_random();
    model(mcls, mscore);
    run_pass("rnd0", 1'b1, mcls, mscore);

    // Abort a pass mid-MAC with reset, then rerun from scratch.
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_sel", longint'(sel), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_done", longint'(done), 0);
    check("arst_cls", longint'(class_out), 0);
    check("arst_score", longint'($signed(max_score)), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_cls   = 0;
    prev_score = 0;
    done_cnt   = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("arst_idle", longint'(done_cnt), 0);
    model(mcls, mscore);
    run_pass("post_rst", 1'b0, mcls, mscore);

    // start held high: one result every N+12 edges, memories refreshed after each result.
    fill_random();
    model(mcls, mscore);
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3 * (N + 12) + 4; j++) begin
      @(negedge clk);
      check("held_done", longint'(done), ((j % (N + 12)) == N + 10) ? 1 : 0);
      check("held_busy", longint'(busy), ((j % (N + 12)) <= N + 10) ? 1 : 0);
      if ((j % (N + 12)) == N + 10) begin
        done_cnt++;
        check("held_cls", longint'(class_out), longint'(mcls));
        check("held_score", longint'($signed(max_score)), mscore);
        fill_random();
        model(mcls, mscore);
      end
    end
    start = 1'b0;
    check("held_count", longint'(done_cnt), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
